// File: rtl/mult_pipe_pkg.sv
// mult_pipe_pkg: shared encodings and the pipeline slot layout for mult_pipe.
// The slot type here matches the default configuration (XLEN=32, RADDR_W=5);
// mult_pipe builds the same layout from its own parameters.
package mult_pipe_pkg;

    localparam int MP_XLEN    = 32;
    localparam int MP_RADDR_W = 5;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef struct packed {
        logic                      valid;
        logic                      we;
        logic [MP_RADDR_W-1:0]     waddr;
        logic [2:0]                funct3;
        logic [2*MP_XLEN-1:0]      product;
        logic [31:0]               instr;
        logic [31:0]               pc;
    } mult_stage_t;

endpackage

// File: rtl/mult_pipe_stage.sv
// mult_pipe_stage: one pipeline register slot with asynchronous reset,
// hold (stall) and clear (flush). Clear takes priority over hold.
module mult_pipe_stage
    import mult_pipe_pkg::*;
#(
    parameter type slot_t = mult_stage_t
) (
    input  logic  clk_i,
    input  logic  rsn_i,
    input  logic  hold,
    input  logic  clear,
    input  slot_t d,
    output slot_t q
);

    // Load the slot on every edge unless held; a clear empties it outright.
    // NOTE: state is written with <= so each slot samples its neighbour's pre-edge value.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: RV32M multiply pipeline (MUL/MULH/MULHSU/MULHU) between execute
// and integer writeback. The product is formed from the inputs and registered
// into stage 1; later stages carry it unchanged. Latency equals STAGES.
// Optional build macro MULT_PIPE_FWD_EN: adds fwd_* ports mirroring the final
// stage and removes the final stage from the decode hazard check.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int STAGES  = 5,
    parameter int RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rsn_i,
    input  logic               exe_valid_i,
    input  logic [31:0]        exe_instruction_i,
    input  logic [31:0]        exe_pc_i,
    input  logic [XLEN-1:0]    exe_rs1_data_i,
    input  logic [XLEN-1:0]    exe_rs2_data_i,
    input  logic [RADDR_W-1:0] exe_write_addr_i,
    input  logic               exe_int_write_enable_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [RADDR_W-1:0] id_rs1_addr_i,
    input  logic [RADDR_W-1:0] id_rs2_addr_i,
    output logic               wb_valid_o,
    output logic [XLEN-1:0]    wb_int_write_data_o,
    output logic [RADDR_W-1:0] wb_write_addr_o,
    output logic               wb_int_write_enable_o,
    output logic [31:0]        wb_instruction_o,
    output logic [31:0]        wb_pc_o,
`ifdef MULT_PIPE_FWD_EN
    output logic               fwd_valid_o,
    output logic [RADDR_W-1:0] fwd_addr_o,
    output logic [XLEN-1:0]    fwd_data_o,
`endif
    output logic               busy_o,
    output logic               mult_hazard_o
);

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [RADDR_W-1:0]    waddr;
        logic [2:0]            funct3;
        logic [2*XLEN-1:0]     product;
        logic [31:0]           instr;
        logic [31:0]           pc;
    } stage_t;

`ifdef MULT_PIPE_FWD_EN
    localparam int HAZ_STAGES = STAGES - 1;
`else
    localparam int HAZ_STAGES = STAGES;
`endif

    logic [2:0]       funct3;
    logic             accept;
    logic             sign_a;
    logic             sign_b;
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] product;
    stage_t           in_slot;
    stage_t           stage_d [STAGES];
    stage_t           stage_q [STAGES];
    stage_t           last;

    assign funct3 = exe_instruction_i[14:12];
    assign accept = exe_valid_i
                 && (exe_instruction_i[31:25] == F7_MULDIV)
                 && (exe_instruction_i[6:0]   == OPC_OP)
                 && !funct3[2];

    // rs1 is signed for MULH/MULHSU, rs2 only for MULH. Sign-extending to the
    // full 2*XLEN width gives the same low 2*XLEN product bits as an (XLEN+1)-bit
    // signed multiply, so a plain unsigned multiply can be used.
    assign sign_a  = ((funct3 == F3_MULH) || (funct3 == F3_MULHSU)) && exe_rs1_data_i[XLEN-1];
    assign sign_b  = (funct3 == F3_MULH) && exe_rs2_data_i[XLEN-1];
    assign ext_a   = {{XLEN{sign_a}}, exe_rs1_data_i};
    assign ext_b   = {{XLEN{sign_b}}, exe_rs2_data_i};
    assign product = ext_a * ext_b;

    // Build the stage-1 entry; anything not accepted enters as an all-zero bubble.
    // NOTE: assigning a full default first keeps this block free of inferred latches.
    always_comb begin
        in_slot = '0;
        if (accept) begin
            in_slot.valid   = 1'b1;
            in_slot.we      = exe_int_write_enable_i;
            in_slot.waddr   = exe_write_addr_i;
            in_slot.funct3  = funct3;
            in_slot.product = product;
            in_slot.instr   = exe_instruction_i;
            in_slot.pc      = exe_pc_i;
        end
    end

    assign stage_d[0] = in_slot;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g > 0) begin : g_link
            assign stage_d[g] = stage_q[g-1];
        end
        mult_pipe_stage #(.slot_t(stage_t)) u_stage (
            .clk_i (clk_i),
            .rsn_i (rsn_i),
            .hold  (stall_i),
            .clear (flush_i),
            .d     (stage_d[g]),
            .q     (stage_q[g])
        );
    end

    assign last = stage_q[STAGES-1];

    assign wb_valid_o            = last.valid;
    assign wb_int_write_data_o   = (last.funct3 == F3_MUL) ? last.product[XLEN-1:0]
                                                           : last.product[2*XLEN-1:XLEN];
    assign wb_write_addr_o       = last.waddr;
    assign wb_int_write_enable_o = last.valid & last.we;
    assign wb_instruction_o      = last.instr;
    assign wb_pc_o               = last.pc;

`ifdef MULT_PIPE_FWD_EN
    assign fwd_valid_o = wb_int_write_enable_o;
    assign fwd_addr_o  = last.waddr;
    assign fwd_data_o  = wb_int_write_data_o;
`endif

    // Occupancy and decode hazard: a pending write to a non-zero source register stalls decode.
    always_comb begin
        busy_o        = 1'b0;
        mult_hazard_o = 1'b0;
        for (int n = 0; n < STAGES; n++) begin
            busy_o = busy_o | stage_q[n].valid;
            if ((n < HAZ_STAGES) && stage_q[n].valid && stage_q[n].we
                && (stage_q[n].waddr != '0)
                && ((stage_q[n].waddr == id_rs1_addr_i) || (stage_q[n].waddr == id_rs2_addr_i))) begin
                mult_hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed and randomized stimulus for mult_pipe, checked every
// cycle against a queue-based model of in-flight instructions.
module tb_mult_pipe;

    localparam int XLEN    = 32;
    localparam int STAGES  = 5;
    localparam int RADDR_W = 5;
`ifdef MULT_PIPE_FWD_EN
    localparam int HZ_LAST = STAGES - 1;
    localparam bit FWD     = 1'b1;
`else
    localparam int HZ_LAST = STAGES;
    localparam bit FWD     = 1'b0;
`endif

    logic               clk_i = 1'b0;
    logic               rsn_i;
    logic               exe_valid_i;
    logic [31:0]        exe_instruction_i;
    logic [31:0]        exe_pc_i;
    logic [XLEN-1:0]    exe_rs1_data_i;
    logic [XLEN-1:0]    exe_rs2_data_i;
    logic [RADDR_W-1:0] exe_write_addr_i;
    logic               exe_int_write_enable_i;
    logic               stall_i;
    logic               flush_i;
    logic [RADDR_W-1:0] id_rs1_addr_i;
    logic [RADDR_W-1:0] id_rs2_addr_i;
    logic               wb_valid_o;
    logic [XLEN-1:0]    wb_int_write_data_o;
    logic [RADDR_W-1:0] wb_write_addr_o;
    logic               wb_int_write_enable_o;
    logic [31:0]        wb_instruction_o;
    logic [31:0]        wb_pc_o;
    logic               busy_o;
    logic               mult_hazard_o;
`ifdef MULT_PIPE_FWD_EN
    logic               fwd_valid_o;
    logic [RADDR_W-1:0] fwd_addr_o;
    logic [XLEN-1:0]    fwd_data_o;
`endif

    mult_pipe #(.XLEN(XLEN), .STAGES(STAGES), .RADDR_W(RADDR_W)) dut (
        .clk_i                  (clk_i),
        .rsn_i                  (rsn_i),
        .exe_valid_i            (exe_valid_i),
        .exe_instruction_i      (exe_instruction_i),
        .exe_pc_i               (exe_pc_i),
        .exe_rs1_data_i         (exe_rs1_data_i),
        .exe_rs2_data_i         (exe_rs2_data_i),
        .exe_write_addr_i       (exe_write_addr_i),
        .exe_int_write_enable_i (exe_int_write_enable_i),
        .stall_i                (stall_i),
        .flush_i                (flush_i),
        .id_rs1_addr_i          (id_rs1_addr_i),
        .id_rs2_addr_i          (id_rs2_addr_i),
        .wb_valid_o             (wb_valid_o),
        .wb_int_write_data_o    (wb_int_write_data_o),
        .wb_write_addr_o        (wb_write_addr_o),
        .wb_int_write_enable_o  (wb_int_write_enable_o),
        .wb_instruction_o       (wb_instruction_o),
        .wb_pc_o                (wb_pc_o),
`ifdef MULT_PIPE_FWD_EN
        .fwd_valid_o            (fwd_valid_o),
        .fwd_addr_o             (fwd_addr_o),
        .fwd_data_o             (fwd_data_o),
`endif
        .busy_o                 (busy_o),
        .mult_hazard_o          (mult_hazard_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;
    logic [31:0] pc_ctr = 32'h1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the ISA definition using 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'b001:  p = sa * sb;
            3'b010:  p = sa * longint'(ub);
            default: p = ua * ub;
        endcase
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, rd, opc};
    endfunction

    // ---------------- behavioural model: list of in-flight instructions ----------------
    typedef struct {
        int          pos;   // 1..STAGES, STAGES = visible on wb
        logic [31:0] data;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    ent_t mq[$];

    always @(negedge rsn_i) mq.delete();

    always @(posedge clk_i) begin
        if (rsn_i) begin
            if (flush_i) begin
                mq.delete();
            end else if (!stall_i) begin
                foreach (mq[i]) mq[i].pos++;
                while (mq.size() > 0 && mq[0].pos > STAGES) void'(mq.pop_front());
                if (exe_valid_i && exe_instruction_i[31:25] == 7'b0000001
                    && exe_instruction_i[6:0] == 7'b0110011 && !exe_instruction_i[14]) begin
                    ent_t e;
                    e.pos   = 1;
                    e.data  = ref_mul(exe_instruction_i[14:12], exe_rs1_data_i, exe_rs2_data_i);
                    e.instr = exe_instruction_i;
                    e.pc    = exe_pc_i;
                    e.rd    = exe_write_addr_i;
                    e.we    = exe_int_write_enable_i;
                    mq.push_back(e);
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk_i) begin
        if (cmp_en) begin
            logic        e_valid, e_we, e_haz;
            logic [31:0] e_data, e_instr, e_pc;
            logic [4:0]  e_rd;
            e_valid = 0; e_we = 0; e_haz = 0;
            e_data = 0; e_instr = 0; e_pc = 0; e_rd = 0;
            foreach (mq[i]) begin
                if (mq[i].pos == STAGES) begin
                    e_valid = 1; e_we = mq[i].we; e_data = mq[i].data;
                    e_instr = mq[i].instr; e_pc = mq[i].pc; e_rd = mq[i].rd;
                end
                if (mq[i].pos <= HZ_LAST && mq[i].we && mq[i].rd != 0
                    && (mq[i].rd == id_rs1_addr_i || mq[i].rd == id_rs2_addr_i))
                    e_haz = 1;
            end
            check("wb_valid", wb_valid_o, e_valid);
            check("wb_we", wb_int_write_enable_o, e_valid & e_we);
            check("wb_data", wb_int_write_data_o, e_data);
            check("wb_addr", wb_write_addr_o, e_rd);
            check("wb_instr", wb_instruction_o, e_instr);
            check("wb_pc", wb_pc_o, e_pc);
            check("busy", busy_o, mq.size() > 0);
            check("hazard", mult_hazard_o, e_haz);
`ifdef MULT_PIPE_FWD_EN
            check("fwd_valid", fwd_valid_o, e_valid & e_we);
            check("fwd_data", fwd_data_o, e_valid & e_we ? e_data : wb_int_write_data_o);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        exe_valid_i = 0; exe_instruction_i = 0; exe_pc_i = 0;
        exe_rs1_data_i = 0; exe_rs2_data_i = 0; exe_write_addr_i = 0;
        exe_int_write_enable_i = 0;
    endtask

    task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic we);
        exe_valid_i = 1;
        exe_instruction_i = mk_instr(f7, f3, rd, opc);
        pc_ctr += 4;
        exe_pc_i = pc_ctr;
        exe_rs1_data_i = a;
        exe_rs2_data_i = b;
        exe_write_addr_i = rd;
        exe_int_write_enable_i = we;
    endtask

    initial begin
        idle();
        stall_i = 0; flush_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        rsn_i = 1;
        #3 rsn_i = 0;
        #1;
        check("rst_valid", wb_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_data", wb_int_write_data_o, 0);
        cmp_en = 1'b1;
        repeat (2) tick();
        rsn_i = 1;

        // MUL 7 * -3 -> x5, visible exactly STAGES cycles after presentation
        issue(7'b0000001, 3'b000, 7'b0110011, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b1);
        tick();
        idle();
        repeat (3) begin
            tick();
            check("mul_early_we", wb_int_write_enable_o, 0);
        end
        tick();
        check("mul_data", wb_int_write_data_o, 32'hFFFFFFEB);
        check("mul_addr", wb_write_addr_o, 5);
        check("mul_we", wb_int_write_enable_o, 1);
        tick();
        check("mul_we_pulse", wb_int_write_enable_o, 0);

        // MULH / MULHSU / MULHU on 0x80000000 x 0xFFFFFFFF, back to back
        issue(7'b0000001, 3'b001, 7'b0110011, 32'h80000000, 32'hFFFFFFFF, 5'd10, 1'b1);
        tick();
        issue(7'b0000001, 3'b010, 7'b0110011, 32'h80000000, 32'hFFFFFFFF, 5'd11, 1'b1);
        tick();
        issue(7'b0000001, 3'b011, 7'b0110011, 32'h80000000, 32'hFFFFFFFF, 5'd12, 1'b1);
        tick();
        idle();
        repeat (2) tick();
        check("mulh", wb_int_write_data_o, 32'h00000000);
        tick();
        check("mulhsu", wb_int_write_data_o, 32'h80000000);
        tick();
        check("mulhu", wb_int_write_data_o, 32'h7FFFFFFF);
        repeat (3) tick();

        // ADD and DIV are never accepted
        issue(7'b0000000, 3'b000, 7'b0110011, 32'd1, 32'd2, 5'd6, 1'b1);
        tick();
        issue(7'b0000001, 3'b100, 7'b0110011, 32'd9, 32'd3, 5'd7, 1'b1);
        tick();
        idle();
        repeat (6) begin
            check("nonmul_busy", busy_o, 0);
            check("nonmul_we", wb_int_write_enable_o, 0);
            tick();
        end

        // MULs to x1..x4 with a 2-cycle stall mid-stream
        issue(7'b0000001, 3'b000, 7'b0110011, 32'd2, 32'd3, 5'd1, 1'b1);
        tick();
        issue(7'b0000001, 3'b000, 7'b0110011, 32'd4, 32'd5, 5'd2, 1'b1);
        tick();
        issue(7'b0000001, 3'b000, 7'b0110011, 32'd6, 32'd7, 5'd3, 1'b1);
        stall_i = 1;
        repeat (2) tick();
        stall_i = 0;
        tick();
        issue(7'b0000001, 3'b000, 7'b0110011, 32'd8, 32'd9, 5'd4, 1'b1);
        tick();
        idle();
        for (int r = 1; r <= 4; r++) begin
            tick();
            check("stall_order_addr", wb_write_addr_o, r);
            check("stall_order_we", wb_int_write_enable_o, 1);
        end
        tick();
        check("stall_no_dup", wb_int_write_enable_o, 0);

        // Hazard on x9 until writeback (drops in the writeback cycle with forwarding)
        repeat (2) tick();
        id_rs2_addr_i = 5'd9;
        issue(7'b0000001, 3'b000, 7'b0110011, 32'd3, 32'd4, 5'd9, 1'b1);
        check("haz_empty", mult_hazard_o, 0);
        tick();
        idle();
        for (int s = 1; s < STAGES; s++) begin
            check("haz_inflight", mult_hazard_o, 1);
            tick();
        end
        check("haz_wb_cycle", mult_hazard_o, FWD ? 0 : 1);
        check("haz_wb_data", wb_int_write_data_o, 32'd12);
`ifdef MULT_PIPE_FWD_EN
        check("fwd_valid_wb", fwd_valid_o, 1);
        check("fwd_data_wb", fwd_data_o, 32'd12);
`endif
        tick();
        check("haz_after", mult_hazard_o, 0);
        // destination x0 never raises the hazard
        id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        issue(7'b0000001, 3'b000, 7'b0110011, 32'd3, 32'd4, 5'd0, 1'b1);
        tick();
        idle();
        repeat (STAGES) begin
            check("haz_x0", mult_hazard_o, 0);
            tick();
        end

        // Flush together with stall, three in flight
        for (int k = 0; k < 3; k++) begin
            issue(7'b0000001, 3'b000, 7'b0110011, 32'd5 + k, 32'd11, 5'd20 + 5'(k), 1'b1);
            tick();
        end
        idle();
        check("pre_flush_busy", busy_o, 1);
        stall_i = 1; flush_i = 1;
        tick();
        stall_i = 0; flush_i = 0;
        check("flush_busy", busy_o, 0);
        repeat (STAGES + 1) begin
            tick();
            check("flush_no_wb", wb_int_write_enable_o, 0);
        end

        // Asynchronous reset mid-stream: outputs clear immediately
        for (int k = 0; k < STAGES; k++) begin
            issue(7'b0000001, 3'b011, 7'b0110011, 32'hFFFF0000 + k, 32'hFFFFFFFF, 5'd1 + 5'(k), 1'b1);
            tick();
        end
        idle();
        check("pre_rst_we", wb_int_write_enable_o, 1);
        #2 rsn_i = 0;
        #1;
        check("async_rst_valid", wb_valid_o, 0);
        check("async_rst_we", wb_int_write_enable_o, 0);
        check("async_rst_data", wb_int_write_data_o, 0);
        check("async_rst_pc", wb_pc_o, 0);
        check("async_rst_busy", busy_o, 0);
        tick();
        rsn_i = 1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int kind;
            logic [31:0] a, b;
            kind = $urandom_range(0, 11);
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            if ($urandom_range(0, 3) == 0) idle();
            else if (kind < 8)
                issue(7'b0000001, 3'(kind % 4), 7'b0110011, a, b, 5'($urandom_range(0, 7)), $urandom_range(0, 5) != 0);
            else if (kind == 8)
                issue(7'b0000000, 3'b000, 7'b0110011, a, b, 5'($urandom_range(0, 7)), 1'b1);
            else if (kind == 9)
                issue(7'b0000001, 3'(4 + $urandom_range(0, 3)), 7'b0110011, a, b, 5'($urandom_range(0, 7)), 1'b1);
            else
                issue(7'b0000001, 3'b000, 7'b0010011, a, b, 5'($urandom_range(0, 7)), 1'b1);
            exe_valid_i   = exe_valid_i & ($urandom_range(0, 9) != 0);
            stall_i       = ($urandom_range(0, 7) == 0);
            flush_i       = ($urandom_range(0, 29) == 0);
            id_rs1_addr_i = 5'($urandom_range(0, 7));
            id_rs2_addr_i = 5'($urandom_range(0, 7));
            if (i == 1500) begin
                #2 rsn_i = 0;
                tick();
                rsn_i = 1;
            end else begin
                tick();
            end
        end
        idle();
        stall_i = 0; flush_i = 0;
        repeat (STAGES + 3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
